xor_gate_unit: RTL and testbench
================================

Name: xor_gate_unit

Overview:
- Registered, handshaked bitwise XOR unit: `out` = `in1` XOR `in2` across WIDTH lanes.
- Also reports a popcount of the result, i.e. the number of differing bits between the operands.
- Used as a compare/difference stage between two equal-width data streams.
- One-entry output register; valid/ready on both sides; full throughput when downstream is ready.

Parameters:
- WIDTH, 1, lane count (bit width of `in1`, `in2`, `out`); legal range 1..64.
- CNT_W, $clog2(WIDTH+1), width of `diff_cnt`; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair present.
- in_ready  output  1  unit accepts operand pair this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- out_valid  output  1  result register holds valid data.
- out_ready  input  1  downstream accepts result.
- out  output  WIDTH  registered in1 ^ in2.
- diff_cnt  output  CNT_W  registered count of 1 bits in `out`.
- parity  output  1  registered XOR-reduction of `out` (only with XOR_GATE_PARITY_EN).

Behaviour:
- Reset (async assert, sync release by design convention):
  - `out_valid` = 0, `out` = 0, `diff_cnt` = 0, `parity` = 0.
  - Reset mid-transfer discards the held result; nothing is replayed.
- Per-lane function: `out[i]` = `in1[i]` XOR `in2[i]`. Truth table per lane: 00→0, 01→1, 10→1, 11→0.
- `in_ready` = !`out_valid` || `out_ready` (combinational; no combinational path from `in_valid` to `in_ready`).
- Accept: `in_valid` && `in_ready` at a rising edge.
  - Capture result into the output register.
  - `out_valid` <= 1 on that edge.
- Latency: exactly 1 cycle from accept to `out_valid` = 1 with the corresponding result.
- Drain:
  - `out_valid` && `out_ready` with no new accept → `out_valid` <= 0.
  - `out`, `diff_cnt` and `parity` hold their last values (not cleared).
- Simultaneous drain and accept: the register reloads with the new result and `out_valid` stays 1. This gives one result per cycle sustained.
- Stall: `out_valid` && !`out_ready` → `in_ready` = 0.
  - `out`, `diff_cnt` and `parity` are held stable until consumed.
  - Inputs are ignored.
- `diff_cnt` = popcount(in1 ^ in2), computed combinationally before the register.
  - Range 0..WIDTH; saturation is not needed by construction.
  - Example: all-ones vs all-zeros gives `diff_cnt` = WIDTH.
- X on `in1`/`in2` while not accepted has no effect on outputs.
- No internal state other than the output register (`out_valid`, `out`, `diff_cnt`, `parity`).

Optional Feature:
- Macro XOR_GATE_PARITY_EN.
- Defined:
  - `parity` port exists.
  - `parity` register = XOR-reduce(in1 ^ in2), captured on accept.
  - Reset value 0; held under stall like `out`.
- Undefined:
  - `parity` port and its register are absent.
  - All other behaviour is identical.

Test Plan:
- Reset: assert `rst` asynchronously mid-cycle with `out_valid` = 1 → `out_valid`, `out` and `diff_cnt` go to 0 immediately, before the next clock edge.
- Truth table, WIDTH=1, `out_ready`=1, apply `in1`/`in2` = 0/0, 0/1, 1/0, 1/1 on consecutive cycles:
  - Each result appears 1 cycle after its accept: 0, 1, 1, 0.
  - `diff_cnt` = 0, 1, 1, 0.
- Wide operands, WIDTH=8: `in1`=8'hFF, `in2`=8'h00 → `out`=8'hFF, `diff_cnt`=8. Then `in1`=8'hA5, `in2`=8'hA5 → `out`=8'h00, `diff_cnt`=0.
- Backpressure: hold `out_ready`=0 with `out_valid`=1, then present a new pair →
  - `in_ready`=0 and `out` stays stable.
  - On `out_ready`=1 the held result is consumed and the new pair is accepted in the same cycle.
- Throughput: 16 back-to-back pairs with `out_ready`=1 → 16 results on 16 consecutive cycles, none dropped or duplicated.
- With XOR_GATE_PARITY_EN defined, WIDTH=8: `in1`=8'h07, `in2`=8'h00 → `parity`=1. Then `in1`=8'h03, `in2`=8'h00 → `parity`=0.

Source files
------------

// File: rtl/xor_gate_unit.sv
// xor_gate_unit: registered valid/ready bitwise XOR with popcount of differing bits.
// Optional parity output enabled by defining XOR_GATE_PARITY_EN.
module xor_gate_unit #(
   parameter  int WIDTH = 1,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] diff_cnt
`ifdef XOR_GATE_PARITY_EN
  ,output logic             parity
`endif
);
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             acc;
   assign in_ready  = !valid_q || out_ready;
   assign acc       = in_valid && in_ready;
   assign out_valid = valid_q;
   assign out       = out_q;
   assign diff_cnt  = cnt_q;
   // Lane XOR, its popcount, and next valid (set on accept, cleared on drain)
   always_comb begin
      out_d = in1 ^ in2;
      cnt_d = '0;
      for (int i = 0; i < WIDTH; i++)
         cnt_d = cnt_d + CNT_W'(out_d[i]);
      valid_d = acc || (valid_q && !out_ready);
   end
`ifdef XOR_GATE_PARITY_EN
   logic par_q;
   assign parity = par_q;
   // Parity of the result, loaded alongside out and held under stall
   always_ff @(posedge clk or posedge rst)
      if (rst) par_q <= 1'b0;
      else if (acc) par_q <= ^out_d;
`endif
   // Output register: data loads only on accept, so stalls and drains keep the last result
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid_q <= 1'b0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         if (acc) begin
            out_q <= out_d;
            cnt_q <= cnt_d;
         end
      end
endmodule

// File: tb/tb_xor_gate_unit.sv
// tb_xor_gate_unit: directed checks of xor_gate_unit at WIDTH=1 and WIDTH=8.
module tb_xor_gate_unit;
   logic       clk = 0, rst = 1;
   logic       v1 = 0, r1 = 1, a1 = 0, b1 = 0;
   logic       ir1, ov1, o1, c1;
   logic       v8 = 0, r8 = 1;
   logic [7:0] a8 = 0, b8 = 0, o8, ea;
   logic       ir8, ov8;
   logic [3:0] c8;
   logic       p8;
   int         n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   xor_gate_unit #(.WIDTH(1)) u1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_ready(ir1), .in1(a1), .in2(b1),
      .out_valid(ov1), .out_ready(r1), .out(o1), .diff_cnt(c1)
`ifdef XOR_GATE_PARITY_EN
     ,.parity()
`endif
   );

   xor_gate_unit #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .in1(a8), .in2(b8),
      .out_valid(ov8), .out_ready(r8), .out(o8), .diff_cnt(c8)
`ifdef XOR_GATE_PARITY_EN
     ,.parity(p8)
`endif
   );
`ifndef XOR_GATE_PARITY_EN
   assign p8 = 1'b0;
`endif

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ov1", ov1, 0); chk("rst_o1", o1, 0); chk("rst_c1", c1, 0);
      chk("rst_ov8", ov8, 0); chk("rst_o8", o8, 0); chk("rst_c8", c8, 0);
      rst = 0;
      @(negedge clk);
      chk("idle_ir1", ir1, 1); chk("idle_ir8", ir8, 1);
      // truth table, WIDTH=1
      v1 = 1; a1 = 0; b1 = 0;
      @(negedge clk);
      chk("tt00_v", ov1, 1); chk("tt00_o", o1, 0); chk("tt00_c", c1, 0);
      a1 = 0; b1 = 1;
      @(negedge clk);
      chk("tt01_o", o1, 1); chk("tt01_c", c1, 1);
      a1 = 1; b1 = 0;
      @(negedge clk);
      chk("tt10_o", o1, 1); chk("tt10_c", c1, 1);
      a1 = 1; b1 = 1;
      @(negedge clk);
      chk("tt11_o", o1, 0); chk("tt11_c", c1, 0); chk("tt11_v", ov1, 1);
      v1 = 0;
      @(negedge clk);
      chk("tt_drain_v", ov1, 0);
      // wide operands, WIDTH=8
      v8 = 1; a8 = 8'hFF; b8 = 8'h00;
      @(negedge clk);
      chk("w_ff_v", ov8, 1); chk("w_ff_o", o8, 8'hFF); chk("w_ff_c", c8, 8);
      a8 = 8'hA5; b8 = 8'hA5;
      @(negedge clk);
      chk("w_a5_o", o8, 8'h00); chk("w_a5_c", c8, 0);
      a8 = 8'h07; b8 = 8'h00;
      @(negedge clk);
      chk("w_07_o", o8, 8'h07); chk("w_07_c", c8, 3);
`ifdef XOR_GATE_PARITY_EN
      chk("par_07", p8, 1);
`endif
      a8 = 8'h03; b8 = 8'h00;
      @(negedge clk);
      chk("w_03_o", o8, 8'h03); chk("w_03_c", c8, 2);
`ifdef XOR_GATE_PARITY_EN
      chk("par_03", p8, 0);
`endif
      v8 = 0;
      @(negedge clk);
      chk("drain_v", ov8, 0); chk("drain_hold_o", o8, 8'h03); chk("drain_hold_c", c8, 2);
      // backpressure
      r8 = 0; v8 = 1; a8 = 8'h3C; b8 = 8'h0F;
      @(negedge clk);
      chk("bp_v", ov8, 1); chk("bp_o", o8, 8'h33); chk("bp_ir", ir8, 0);
      a8 = 8'hF0; b8 = 8'h0F;
      @(negedge clk);
      chk("bp_hold_o", o8, 8'h33); chk("bp_hold_c", c8, 4); chk("bp_hold_ir", ir8, 0);
      @(negedge clk);
      chk("bp_hold2_o", o8, 8'h33); chk("bp_hold2_v", ov8, 1);
      r8 = 1;
      #1 chk("bp_release_ir", ir8, 1);
      @(negedge clk);
      chk("bp_new_v", ov8, 1); chk("bp_new_o", o8, 8'hFF); chk("bp_new_c", c8, 8);
      v8 = 0;
      @(negedge clk);
      chk("bp_drain_v", ov8, 0);
      // throughput: 16 back-to-back pairs
      for (int i = 0; i < 16; i++) begin
         ea = a8 ^ b8;
         v8 = 1; a8 = 8'(i * 8'h13); b8 = ~8'(i);
         @(negedge clk);
         chk("tp_v", ov8, 1);
         chk("tp_o", o8, a8 ^ b8);
         chk("tp_c", c8, $countones(a8 ^ b8));
         if (i > 0) chk("tp_changed", (o8 != ea) || (i == 0), 1);
      end
      v8 = 0;
      @(negedge clk);
      chk("tp_end_v", ov8, 0);
      // async reset mid-cycle with a held result
      r8 = 0; v8 = 1; a8 = 8'hFF; b8 = 8'h00;
      @(negedge clk);
      chk("ar_pre_v", ov8, 1);
      v8 = 0;
      #2 rst = 1;
      #1;
      chk("ar_v", ov8, 0); chk("ar_o", o8, 0); chk("ar_c", c8, 0); chk("ar_p", p8, 0);
      rst = 0; r8 = 1;
      @(negedge clk);
      chk("ar_noreplay_v", ov8, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
